// File: rtl/tx_buffer_pkg.sv
// Shared definitions for the host-to-FPGA transmit buffer.
//   PKT_WORDS     : words per USB packet (have_space threshold, per-burst write cap)
//   WCNT_W        : width of the per-burst write counter (one spare bit acts as the cap flag)
//   burst_state_e : burst tracker encoding
//   DBG_*         : debugbus bit positions
package tx_buffer_pkg;

  localparam int unsigned PKT_WORDS = 256;
  localparam int unsigned WCNT_W    = 9;
  localparam int unsigned DBG_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    CAPPED = 2'd2
  } burst_state_e;

  localparam int unsigned DBG_WR          = 0;
  localparam int unsigned DBG_FULL        = 1;
  localparam int unsigned DBG_EMPTY       = 2;
  localparam int unsigned DBG_HAVE_SPACE  = 3;
  localparam int unsigned DBG_TX_OVERRUN  = 4;
  localparam int unsigned DBG_TX_UNDERRUN = 5;

endpackage

// File: rtl/tx_buffer_fifo_sc.sv
// Single-clock FIFO backed by a RAM array with a registered read port.
//   clk, rst : clock and synchronous active-high reset
//   din, we  : write data and write request (dropped when full)
//   dout, re : registered read data and read request (ignored when empty)
//   full, empty, count : occupancy derived from the registered word count
module fifo_sc #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          we,
  output logic [DW-1:0] dout,
  input  logic          re,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          push, pop;

  // Status comes from the registered count, so a full FIFO refuses a push even if it pops this cycle
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Pointer, count and read-register next state
  always_comb begin
    push     = we & ~full;
    pop      = re & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    dout_d   = pop ? mem[rd_ptr_q] : dout_q;
  end

  // RAM write port; left without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/tx_buffer.sv
// GPIF-to-local transmit buffer: GPIF bursts on WR are written into a FIFO
// (capped at one packet per WR assertion), a local consumer pops with txstrobe.
//   usbclk, rst              : sole clock, synchronous active-high reset
//   usbdata, WR              : GPIF write data and burst strobe
//   have_space               : a full packet fits in the FIFO
//   txstrobe, txdata, txack  : pop request, popped word, pop-accepted marker
//   tx_overrun, tx_underrun  : sticky error flags, cleared by clear_status
//   debugbus                 : registered status snapshot
module tx_buffer
  import tx_buffer_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 11
) (
  input  logic             usbclk,
  input  logic             rst,
  input  logic [DW-1:0]    usbdata,
  input  logic             WR,
  output logic             have_space,
  input  logic             txstrobe,
  output logic [DW-1:0]    txdata,
  output logic             txack,
  output logic             tx_overrun,
  output logic             tx_underrun,
  input  logic             clear_status,
  output logic [DBG_W-1:0] debugbus
);

  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  burst_state_e      state_q, state_d;
  logic [WCNT_W-1:0] write_count_q, write_count_d;
  logic              have_space_q, have_space_d;
  logic              txack_q, txack_d;
  logic              tx_overrun_q, tx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic [DBG_W-1:0]  debug_q, debug_d;

  logic              wr_gate_c, we_c;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, count_nxt;
  logic              push_ok, pop_ok, overrun_ev, underrun_ev;

  fifo_sc #(.DW(DW), .AW(AW)) u_fifo (
    .clk   (usbclk),
    .rst   (rst),
    .din   (usbdata),
    .we    (we_c),
    .dout  (txdata),
    .re    (txstrobe),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Burst tracker state register
  always_ff @(posedge usbclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Burst tracker next state; WR low always ends the burst
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (WR) state_d = BURST;
      BURST:   if (!WR) state_d = IDLE;
               else if (write_count_q == WCNT_W'(PKT_WORDS)) state_d = CAPPED;
      CAPPED:  if (!WR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst gate: the counter's top bit closes the write enable after one packet
  always_comb begin
    wr_gate_c = ~write_count_q[WCNT_W-1];
    we_c      = WR & wr_gate_c;
  end

  // Counter, handshake, have_space, sticky flags and debug snapshot
  always_comb begin
    write_count_d = WR ? write_count_q + WCNT_W'(wr_gate_c) : '0;
    push_ok       = we_c & ~fifo_full;
    pop_ok        = txstrobe & ~fifo_empty;
    overrun_ev    = we_c & fifo_full;
    underrun_ev   = txstrobe & fifo_empty;
    count_nxt     = fifo_count + CW'(push_ok) - CW'(pop_ok);
    have_space_d  = (CW'(DEPTH) - count_nxt) >= CW'(PKT_WORDS);
    txack_d       = pop_ok;
    // A new event outranks a same-cycle clear
    tx_overrun_d  = (overrun_ev | clear_status) ? overrun_ev : tx_overrun_q;
    tx_underrun_d = (underrun_ev | clear_status) ? underrun_ev : tx_underrun_q;

    debug_d                  = '0;
    debug_d[DBG_WR]          = WR;
    debug_d[DBG_FULL]        = fifo_full;
    debug_d[DBG_EMPTY]       = fifo_empty;
    debug_d[DBG_HAVE_SPACE]  = have_space_q;
    debug_d[DBG_TX_OVERRUN]  = tx_overrun_q;
    debug_d[DBG_TX_UNDERRUN] = tx_underrun_q;
  end

  always_ff @(posedge usbclk) begin
    if (rst) begin
      write_count_q <= '0;
      have_space_q  <= 1'b0;
      txack_q       <= 1'b0;
      tx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      debug_q       <= '0;
    end else begin
      write_count_q <= write_count_d;
      have_space_q  <= have_space_d;
      txack_q       <= txack_d;
      tx_overrun_q  <= tx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      debug_q       <= debug_d;
    end
  end

  assign have_space  = have_space_q;
  assign txack       = txack_q;
  assign tx_overrun  = tx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign debugbus    = debug_q;

endmodule

// File: tb/tb_tx_buffer.sv
module tb_tx_buffer;
  import tx_buffer_pkg::*;

  logic        usbclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] usbdata = '0;
  logic        WR = 1'b0;
  logic        have_space;
  logic        txstrobe = 1'b0;
  logic [15:0] txdata;
  logic        txack;
  logic        tx_overrun;
  logic        tx_underrun;
  logic        clear_status = 1'b0;
  logic [15:0] debugbus;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_q[$];

  always #5 usbclk = ~usbclk;

  tx_buffer dut (
    .usbclk       (usbclk),
    .rst          (rst),
    .usbdata      (usbdata),
    .WR           (WR),
    .have_space   (have_space),
    .txstrobe     (txstrobe),
    .txdata       (txdata),
    .txack        (txack),
    .tx_overrun   (tx_overrun),
    .tx_underrun  (tx_underrun),
    .clear_status (clear_status),
    .debugbus     (debugbus)
  );

  task automatic tick();
    @(posedge usbclk);
    #1;
  endtask

  // One WR burst of n words base..base+n-1, then WR low for a cycle; model keeps what should be stored
  task automatic write_burst(input int n, input int base);
    WR = 1'b1;
    for (int i = 0; i < n; i++) begin
      usbdata = 16'(base + i);
      if (i < 256 && model_q.size() < 2048) model_q.push_back(usbdata);
      tick();
    end
    WR = 1'b0;
    usbdata = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (have_space !== 1'b0) begin errors++; $display("FAIL reset_have_space: got %b want 0", have_space); end
    checks++; if (txdata !== 16'h0) begin errors++; $display("FAIL reset_txdata: got %h want 0000", txdata); end
    checks++; if (txack !== 1'b0 || tx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
      errors++; $display("FAIL reset_flags: txack=%b ovr=%b und=%b want 0/0/0", txack, tx_overrun, tx_underrun);
    end
    checks++; if (debugbus !== 16'h0) begin errors++; $display("FAIL reset_debugbus: got %h want 0000", debugbus); end
    checks++; if (dut.fifo_count !== 12'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.fifo_count); end
    rst = 1'b0;
    tick();
    checks++; if (have_space !== 1'b1) begin errors++; $display("FAIL post_reset_have_space: got %b want 1", have_space); end
    checks++; if (debugbus !== 16'h0004) begin errors++; $display("FAIL post_reset_debugbus: got %h want 0004", debugbus); end
  endtask

  task automatic test_burst_cap();
    logic [15:0] exp;
    WR = 1'b1;
    for (int i = 0; i < 300; i++) begin
      usbdata = 16'(i);
      if (i < 256) model_q.push_back(usbdata);
      tick();
    end
    checks++; if (dut.state_q !== CAPPED) begin errors++; $display("FAIL cap_state: got %0d want %0d", dut.state_q, CAPPED); end
    checks++; if (debugbus !== 16'h0009) begin errors++; $display("FAIL cap_debugbus: got %h want 0009", debugbus); end
    checks++; if (dut.fifo_count !== 12'd256) begin errors++; $display("FAIL cap_count: got %0d want 256", dut.fifo_count); end
    checks++; if (tx_overrun !== 1'b0) begin errors++; $display("FAIL cap_overrun: got %b want 0", tx_overrun); end
    WR = 1'b0;
    tick();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL cap_idle: got %0d want %0d", dut.state_q, IDLE); end
    txstrobe = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = model_q.pop_front();
      tick();
      checks++; if (txack !== 1'b1 || txdata !== exp) begin
        errors++; $display("FAIL cap_pop[%0d]: txdata=%h txack=%b want %h/1", i, txdata, txack, exp);
      end
    end
    txstrobe = 1'b0;
    tick();
    checks++; if (dut.fifo_count !== 12'd0) begin errors++; $display("FAIL cap_drained: got %0d want 0", dut.fifo_count); end
  endtask

  task automatic test_have_space();
    logic [15:0] exp;
    for (int k = 0; k < 7; k++) write_burst(256, 16'h1000 + k * 256);
    checks++; if (dut.fifo_count !== 12'd1792 || have_space !== 1'b1) begin
      errors++; $display("FAIL hs_1792: count=%0d have_space=%b want 1792/1", dut.fifo_count, have_space);
    end
    write_burst(1, 16'hA000);
    checks++; if (dut.fifo_count !== 12'd1793 || have_space !== 1'b0) begin
      errors++; $display("FAIL hs_1793: count=%0d have_space=%b want 1793/0", dut.fifo_count, have_space);
    end
    txstrobe = 1'b1;
    exp = model_q.pop_front();
    tick();
    txstrobe = 1'b0;
    checks++; if (txack !== 1'b1 || txdata !== exp) begin
      errors++; $display("FAIL hs_pop: txdata=%h txack=%b want %h/1", txdata, txack, exp);
    end
    checks++; if (dut.fifo_count !== 12'd1792 || have_space !== 1'b1) begin
      errors++; $display("FAIL hs_after_pop: count=%0d have_space=%b want 1792/1", dut.fifo_count, have_space);
    end
  endtask

  task automatic test_overrun();
    logic [15:0] exp;
    write_burst(256, 16'h3000);
    checks++; if (dut.fifo_count !== 12'd2048 || have_space !== 1'b0) begin
      errors++; $display("FAIL ovr_full: count=%0d have_space=%b want 2048/0", dut.fifo_count, have_space);
    end
    checks++; if (debugbus !== 16'h0002) begin errors++; $display("FAIL ovr_debugbus: got %h want 0002", debugbus); end
    write_burst(1, 16'hBEEF);
    checks++; if (tx_overrun !== 1'b1 || dut.fifo_count !== 12'd2048) begin
      errors++; $display("FAIL ovr_drop: ovr=%b count=%0d want 1/2048", tx_overrun, dut.fifo_count);
    end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    checks++; if (tx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", tx_overrun); end
    // Push while full with a same-cycle pop: the push is still dropped
    WR = 1'b1;
    usbdata = 16'hBEEF;
    txstrobe = 1'b1;
    exp = model_q.pop_front();
    tick();
    WR = 1'b0;
    txstrobe = 1'b0;
    checks++; if (txack !== 1'b1 || txdata !== exp) begin
      errors++; $display("FAIL ovr_simul_pop: txdata=%h txack=%b want %h/1", txdata, txack, exp);
    end
    checks++; if (dut.fifo_count !== 12'd2047 || tx_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_simul_drop: count=%0d ovr=%b want 2047/1", dut.fifo_count, tx_overrun);
    end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    txstrobe = 1'b1;
    for (int i = 0; i < 2047; i++) begin
      exp = model_q.pop_front();
      tick();
      checks++; if (txack !== 1'b1 || txdata !== exp) begin
        errors++; $display("FAIL ovr_drain[%0d]: txdata=%h txack=%b want %h/1", i, txdata, txack, exp);
      end
    end
    txstrobe = 1'b0;
    tick();
    checks++; if (dut.fifo_count !== 12'd0 || tx_underrun !== 1'b0) begin
      errors++; $display("FAIL ovr_empty: count=%0d und=%b want 0/0", dut.fifo_count, tx_underrun);
    end
  endtask

  task automatic test_back_to_back();
    WR = 1'b1;
    usbdata = 16'h1234;
    tick();
    usbdata = 16'h5678;
    tick();
    WR = 1'b0;
    tick();
    txstrobe = 1'b1;
    tick();
    checks++; if (txdata !== 16'h1234 || txack !== 1'b1) begin
      errors++; $display("FAIL b2b_first: txdata=%h txack=%b want 1234/1", txdata, txack);
    end
    tick();
    checks++; if (txdata !== 16'h5678 || txack !== 1'b1) begin
      errors++; $display("FAIL b2b_second: txdata=%h txack=%b want 5678/1", txdata, txack);
    end
    tick();
    txstrobe = 1'b0;
    checks++; if (txdata !== 16'h5678 || txack !== 1'b0 || tx_underrun !== 1'b1) begin
      errors++; $display("FAIL b2b_underrun: txdata=%h txack=%b und=%b want 5678/0/1", txdata, txack, tx_underrun);
    end
  endtask

  task automatic test_clear_race();
    txstrobe = 1'b1;
    clear_status = 1'b1;
    tick();
    txstrobe = 1'b0;
    checks++; if (tx_underrun !== 1'b1) begin errors++; $display("FAIL clr_event_wins: got %b want 1", tx_underrun); end
    tick();
    clear_status = 1'b0;
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b want 0", tx_underrun); end
  endtask

  task automatic test_no_bypass();
    // Push into an empty FIFO with a same-cycle pop: nothing is bypassed
    WR = 1'b1;
    usbdata = 16'hC0DE;
    txstrobe = 1'b1;
    tick();
    checks++; if (txack !== 1'b0 || txdata !== 16'h5678 || tx_underrun !== 1'b1 || dut.fifo_count !== 12'd1) begin
      errors++; $display("FAIL nobypass: txack=%b txdata=%h und=%b count=%0d want 0/5678/1/1", txack, txdata, tx_underrun, dut.fifo_count);
    end
    // Push and pop with one word stored: count unchanged
    usbdata = 16'hD00D;
    tick();
    WR = 1'b0;
    checks++; if (txack !== 1'b1 || txdata !== 16'hC0DE || dut.fifo_count !== 12'd1) begin
      errors++; $display("FAIL simul_push_pop: txack=%b txdata=%h count=%0d want 1/c0de/1", txack, txdata, dut.fifo_count);
    end
    tick();
    txstrobe = 1'b0;
    checks++; if (txack !== 1'b1 || txdata !== 16'hD00D || dut.fifo_count !== 12'd0) begin
      errors++; $display("FAIL simul_tail: txack=%b txdata=%h count=%0d want 1/d00d/0", txack, txdata, dut.fifo_count);
    end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] exp;
    WR = 1'b1;
    for (int i = 0; i < 100; i++) begin
      usbdata = 16'(16'h5000 + i);
      tick();
    end
    rst = 1'b1;
    tick();
    model_q.delete();
    checks++; if (dut.fifo_count !== 12'd0 || have_space !== 1'b0 || tx_overrun !== 1'b0 || tx_underrun !== 1'b0) begin
      errors++; $display("FAIL rmb_reset: count=%0d hs=%b ovr=%b und=%b want 0/0/0/0", dut.fifo_count, have_space, tx_overrun, tx_underrun);
    end
    rst = 1'b0;
    for (int j = 0; j < 300; j++) begin
      usbdata = 16'(16'h6000 + j);
      if (j < 256) model_q.push_back(usbdata);
      tick();
      if (j == 0) begin
        checks++; if (have_space !== 1'b1) begin errors++; $display("FAIL rmb_have_space: got %b want 1", have_space); end
      end
    end
    WR = 1'b0;
    tick();
    checks++; if (dut.fifo_count !== 12'd256 || tx_overrun !== 1'b0) begin
      errors++; $display("FAIL rmb_count: count=%0d ovr=%b want 256/0", dut.fifo_count, tx_overrun);
    end
    txstrobe = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = model_q.pop_front();
      tick();
      checks++; if (txack !== 1'b1 || txdata !== exp) begin
        errors++; $display("FAIL rmb_pop[%0d]: txdata=%h txack=%b want %h/1", i, txdata, txack, exp);
      end
    end
    txstrobe = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_burst_cap();
    test_have_space();
    test_overrun();
    test_back_to_back();
    test_clear_race();
    test_no_bypass();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
